// File: rtl/tile_scanner.sv
// tile_scanner: fetches each cell of a COLSxROWS tile map and sweeps its TILE_WxTILE_H pixels; AUTO_REFRESH_EN restarts the sweep after every DONE.
module tile_scanner #(
  parameter int COLS   = 5,
  parameter int ROWS   = 4,
  parameter int TILE_W = 32,
  parameter int TILE_H = 30
) (
  input  logic       clk50M,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] map_cell,
  output logic [4:0] map_addr,
  output logic [7:0] x_position,
  output logic [6:0] y_position,
  output logic [7:0] x0,
  output logic [6:0] y0,
  output logic [1:0] object_select,
  output logic       point_cnt_en,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, SCAN, NEXT, DONE} state_t;
  state_t     r_state;
  logic [4:0] r_idx, r_col, r_row;
  logic [7:0] r_x, r_x0;
  logic [6:0] r_y, r_y0;
  logic [1:0] r_obj;
  logic       r_pce, r_busy, r_done;
  logic [7:0] w_tile_x;
  logic [6:0] w_tile_y;
  logic       w_x_end, w_y_end, w_last, w_col_end;
  assign w_tile_x  = 8'(r_col * TILE_W);
  assign w_tile_y  = 7'(r_row * TILE_H);
  assign w_x_end   = r_x == r_x0 + 8'(TILE_W - 1);
  assign w_y_end   = r_y == r_y0 + 7'(TILE_H - 1);
  assign w_last    = r_idx == 5'(COLS * ROWS - 1);
  assign w_col_end = r_col == 5'(COLS - 1);
  assign map_addr      = r_idx;
  assign x_position    = r_x;
  assign y_position    = r_y;
  assign x0            = r_x0;
  assign y0            = r_y0;
  assign object_select = r_obj;
  assign point_cnt_en  = r_pce;
  assign busy          = r_busy;
  assign done          = r_done;
  // Map sweep FSM: fetch cell, latch it with the tile origin, raster the tile, advance to the next cell.
  always_ff @(posedge clk50M or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_x0    <= '0;
      r_y0    <= '0;
      r_obj   <= '0;
      r_pce   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE:
          if (start) begin
            r_state <= FETCH;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_col   <= '0;
            r_row   <= '0;
          end
        FETCH: r_state <= LATCH;
        LATCH: begin
          r_obj   <= map_cell;
          r_x0    <= w_tile_x;
          r_y0    <= w_tile_y;
          r_x     <= w_tile_x;
          r_y     <= w_tile_y;
          r_pce   <= 1'b1;
          r_state <= SCAN;
        end
        SCAN:
          if (w_x_end && w_y_end) begin
            r_pce   <= 1'b0;
            r_state <= NEXT;
          end else if (w_x_end) begin
            r_x <= r_x0;
            r_y <= r_y + 7'd1;
          end else
            r_x <= r_x + 8'd1;
        NEXT:
          if (w_last) begin
            r_idx   <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx   <= r_idx + 5'd1;
            r_col   <= w_col_end ? 5'd0 : r_col + 5'd1;
            r_row   <= w_col_end ? r_row + 5'd1 : r_row;
            r_state <= FETCH;
          end
        DONE: begin
          r_done <= 1'b0;
`ifdef AUTO_REFRESH_EN
          r_state <= FETCH;
`else
          r_busy  <= 1'b0;
          r_state <= IDLE;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_tile_scanner.sv
// tb_tile_scanner: directed sweeps of tile_scanner checked every cycle against an arithmetic model of the map raster.
module tb_tile_scanner;
  localparam int TILE_CYC = 963;
  localparam int SWEEP    = 20 * TILE_CYC;
  logic       clk50M = 1'b0;
  logic       rst_n  = 1'b1;
  logic       start  = 1'b0;
  logic [1:0] map_cell = 2'd0;
  logic [4:0] map_addr;
  logic [7:0] x_position, x0;
  logic [6:0] y_position, y0;
  logic [1:0] object_select;
  logic       point_cnt_en, busy, done;
  logic [1:0] map [20];
  int errors = 0, checks = 0;
  int pce_cnt = 0, done_cnt = 0;
  bit m_busy = 1'b0;
  int m_t = 0;
  int h_x = 0, h_y = 0, h_x0 = 0, h_y0 = 0, h_obj = 0;

  always #10 clk50M = ~clk50M;

  tile_scanner dut (
    .clk50M(clk50M), .rst_n(rst_n), .start(start), .map_cell(map_cell),
    .map_addr(map_addr), .x_position(x_position), .y_position(y_position),
    .x0(x0), .y0(y0), .object_select(object_select),
    .point_cnt_en(point_cnt_en), .busy(busy), .done(done)
  );

  always @(posedge clk50M) map_cell <= (map_addr < 5'd20) ? map[map_addr] : 2'd0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk50M or negedge rst_n)
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_t    <= 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1'b1;
        m_t    <= 0;
      end
    end else if (m_t == SWEEP) begin
`ifdef AUTO_REFRESH_EN
      m_t <= 0;
`else
      m_busy <= 1'b0;
`endif
    end else
      m_t <= m_t + 1;

  always @(negedge clk50M) begin : cmp
    int k, ph, p, e_addr, e_pce, e_done;
    e_addr = 0;
    e_pce  = 0;
    e_done = 0;
    if (!rst_n) begin
      h_x = 0; h_y = 0; h_x0 = 0; h_y0 = 0; h_obj = 0;
    end else if (m_busy && m_t == SWEEP)
      e_done = 1;
    else if (m_busy) begin
      k  = m_t / TILE_CYC;
      ph = m_t % TILE_CYC;
      e_addr = k;
      if (ph >= 2 && ph < TILE_CYC - 1) begin
        p     = ph - 2;
        e_pce = 1;
        h_x0  = (k % 5) * 32;
        h_y0  = (k / 5) * 30;
        h_x   = h_x0 + p % 32;
        h_y   = h_y0 + p / 32;
        h_obj = map[k];
      end
    end
    chk("busy", busy, (rst_n && m_busy) ? 1 : 0);
    chk("done", done, e_done);
    chk("point_cnt_en", point_cnt_en, e_pce);
    chk("map_addr", map_addr, e_addr);
    chk("x_position", x_position, h_x);
    chk("y_position", y_position, h_y);
    chk("x0", x0, h_x0);
    chk("y0", y0, h_y0);
    chk("object_select", object_select, h_obj);
    pce_cnt  += int'(point_cnt_en);
    done_cnt += int'(done);
  end

  task automatic pulse_start();
    @(posedge clk50M); #1 start = 1'b1;
    @(posedge clk50M); #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 25000) begin
      @(negedge clk50M);
      n++;
      if (done) break;
    end
  endtask

  task automatic wait_tile_scan(input int k);
    int n;
    n = 0;
    while (n < 25000) begin
      @(negedge clk50M);
      n++;
      if (map_addr == 5'(k) && point_cnt_en) break;
    end
    chk("wait_tile_scan", (n < 25000) ? 1 : 0, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pce"}, point_cnt_en, 0);
    chk({tag, "_addr"}, map_addr, 0);
    chk({tag, "_x"}, x_position, 0);
    chk({tag, "_y"}, y_position, 0);
    chk({tag, "_x0"}, x0, 0);
    chk({tag, "_y0"}, y0, 0);
    chk({tag, "_obj"}, object_select, 0);
  endtask

  initial begin
    int n, pce0, done0;
    foreach (map[i]) map[i] = 2'd0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk50M);
    #1 rst_n = 1'b1;
    chk_all_zero("reset");
    // sweep 1: blank map, full timing
    pce0  = pce_cnt;
    done0 = done_cnt;
    pulse_start();
    wait_done(n);
    chk("done_latency", n, 19261);
    chk("pce_total", pce_cnt - pce0, 19200);
    @(negedge clk50M);
    chk("done_width", done, 0);
`ifndef AUTO_REFRESH_EN
    chk("busy_after_done", busy, 0);
`endif
    repeat (5) @(negedge clk50M);
    chk("done_count1", done_cnt - done0, 1);
    // sweep 2: populated map, start re-asserted mid-sweep
    map[0]  = 2'd1;
    map[7]  = 2'd3;
    map[19] = 2'd2;
    done0 = done_cnt;
    pulse_start();
    repeat (498) @(posedge clk50M);
    #1 start = 1'b1;
    @(posedge clk50M); #1 start = 1'b0;
    wait_tile_scan(7);
    chk("t7_obj", object_select, 3);
    chk("t7_x0", x0, 64);
    chk("t7_y0", y0, 30);
    chk("t7_first_x", x_position, 64);
    chk("t7_first_y", y_position, 30);
    repeat (959) @(negedge clk50M);
    chk("t7_last_x", x_position, 95);
    chk("t7_last_y", y_position, 59);
    chk("t7_last_pce", point_cnt_en, 1);
    @(negedge clk50M);
    chk("t7_next_pce", point_cnt_en, 0);
    wait_tile_scan(19);
    chk("t19_x0", x0, 128);
    chk("t19_y0", y0, 90);
    chk("t19_obj", object_select, 2);
    repeat (959) @(negedge clk50M);
    chk("t19_last_x", x_position, 159);
    chk("t19_last_y", y_position, 119);
    @(negedge clk50M);
    chk("t19_next_done", done, 0);
    @(negedge clk50M);
    chk("t19_done", done, 1);
    repeat (5) @(negedge clk50M);
    chk("done_count2", done_cnt - done0, 1);
    // sweep 3: asynchronous reset during tile 3
    done0 = done_cnt;
    pulse_start();
    wait_tile_scan(3);
    repeat (100) @(negedge clk50M);
    #3 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    repeat (3) @(posedge clk50M);
    #1 rst_n = 1'b1;
    pulse_start();
    @(negedge clk50M);
    chk("restart_addr", map_addr, 0);
    chk("restart_busy", busy, 1);
    repeat (1000) @(negedge clk50M);
    chk("restart_addr_t1", map_addr, 1);
    chk("no_done_after_rst", done_cnt - done0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tile_scanner.md
TILE_SCANNER -- requirements
Module: tile_scanner

Interface
REQ-001 Parameter COLS, default 5, number of map columns.
REQ-002 Parameter ROWS, default 4, number of map rows.
REQ-003 Parameter TILE_W, default 32, tile width in pixels.
REQ-004 Parameter TILE_H, default 30, tile height in pixels.
REQ-005 clk50M  input  1  single system clock; all logic on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  request a full-map redraw; sampled only in IDLE.
REQ-008 map_cell  input  2  cell content from the synchronous map RAM: 0 blank, 1 box, 2 barrier, 3 man.
REQ-009 map_addr  output  5  map RAM address, cell index = row*COLS+col.
REQ-010 x_position  output  8  current scan pixel x.
REQ-011 y_position  output  7  current scan pixel y.
REQ-012 x0  output  8  current tile top-left x.
REQ-013 y0  output  7  current tile top-left y.
REQ-014 object_select  output  2  latched map_cell for the current tile.
REQ-015 point_cnt_en  output  1  high on every cycle a tile pixel is presented.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 done  output  1  one-cycle pulse at the end of the map sweep.

Function
REQ-018 FSM states: IDLE, FETCH, LATCH, SCAN, NEXT, DONE.
REQ-019 IDLE -> FETCH when start=1; cell index, col and row cleared to 0 on this transition.
REQ-020 FETCH: map_addr = cell index; lasts 1 cycle to cover the 1-cycle RAM read latency; -> LATCH.
REQ-021 LATCH: object_select <= map_cell, x0 <= col*TILE_W, y0 <= row*TILE_H, x_position <= x0 value, y_position <= y0 value; -> SCAN.
REQ-022 SCAN: point_cnt_en=1; row-major sweep, x increments each cycle; at x0+TILE_W-1, x returns to x0 and y increments.
REQ-023 SCAN ends after exactly TILE_W*TILE_H (960) cycles at pixel (x0+31, y0+29); -> NEXT.
REQ-024 NEXT: col increments; at COLS-1, col wraps to 0 and row increments; after the last cell (index 19) -> DONE, otherwise -> FETCH.
REQ-025 DONE: done=1 for exactly one cycle; -> IDLE.
REQ-026 Outside SCAN, point_cnt_en=0 and x_position, y_position, x0, y0 and object_select hold their values.
REQ-027 Per-tile cost is 963 cycles; a default map takes 20*963 = 19260 cycles from the first FETCH to the last NEXT, then 1 DONE cycle.
REQ-028 start while busy=1 is ignored; no queuing.
REQ-029 Maximum coordinates are 159 and 119; no arithmetic overflows at the 8-bit and 7-bit widths.

Reset
REQ-030 On rst_n=0, at any time, the block enters IDLE immediately.
REQ-031 Reset values: all outputs 0, col, row and cell index 0.
REQ-032 A reset mid-SCAN aborts the sweep; no done pulse is produced; the next start begins again at cell 0.

Configuration
REQ-033 Macro AUTO_REFRESH_EN: when defined, DONE goes directly to FETCH with counters cleared, giving continuous redraw with no start needed after the first; busy stays high; done still pulses each sweep.
REQ-034 Without AUTO_REFRESH_EN, DONE -> IDLE and each sweep requires a start pulse.

Verification
REQ-035 Reset, then one start pulse with all map cells = 0 -> map_addr steps 0..19; point_cnt_en high for 19200 total cycles; a single done pulse after 19261 cycles; busy then low.
REQ-036 Map cell 7 = 3 -> during tile 7, object_select=3, x0=64, y0=30; first pixel (64,30), last pixel (95,59).
REQ-037 Tile 19 -> x0=128, y0=90; last pixel (159,119); the next state is DONE.
REQ-038 start re-asserted at cycle 500 of a sweep -> no effect; exactly one done pulse.
REQ-039 rst_n pulled low during tile 3 SCAN -> all outputs 0 asynchronously; a new start restarts at map_addr 0.
REQ-040 AUTO_REFRESH_EN defined, one start -> done pulses every 19261 cycles and busy stays high continuously.
